instruction_fetcher: RTL and testbench

//  Per-core instruction fetch responder driven by the core scheduler's FSM. When the scheduler enters FETCH,
//  it reads current_pc from program memory over a valid/ready port and returns the 16-bit instruction.
//  It reports progress to the scheduler through fetcher_state. A one-entry PC/instruction buffer skips memory on tight loops.

---
 rtl/gpu_core_pkg.sv | 26 ++
 rtl/fetch_buffer.sv | 50 +++++
 rtl/instruction_fetcher.sv | 159 +++++++++++++++
 tb/tb_instruction_fetcher.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_core_pkg.sv
// Shared core encodings: scheduler and fetcher state values plus PC/instruction widths.
// Used by the scheduler, decoder, LSU and fetcher.
package gpu_core_pkg;

  localparam int PC_BITS    = 8;
  localparam int INSTR_BITS = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } sched_state_t;

  typedef enum logic [2:0] {
    F_IDLE     = 3'b000,
    F_FETCHING = 3'b001,
    F_FETCHED  = 3'b010,
    F_ERROR    = 3'b011
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry {valid, pc, data} buffer: combinational lookup, synchronous fill and invalidate.
// Invalidate wins over a same-cycle fill.
module fetch_buffer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_pc,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              invalidate
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    data_d  = data_q;
    if (invalidate) begin
      valid_d = 1'b0;
    end else if (fill_en) begin
      valid_d = 1'b1;
      pc_d    = fill_pc;
      data_d  = fill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
    end
  end

  assign hit      = valid_q && (pc_q == lookup_pc);
  assign hit_data = data_q;

endmodule

// File: rtl/instruction_fetcher.sv
// Per-core instruction fetch responder: fetch FSM, timeout counter, abort/drop flag,
// registered memory request and instruction outputs, backed by a one-entry fetch buffer.
module instruction_fetcher
  import gpu_core_pkg::*;
#(
  parameter int PROGRAM_ADDR_BITS = 8,
  parameter int PROGRAM_DATA_BITS = 16,
  parameter int TIMEOUT_CYCLES    = 64,
  parameter int BUFFER_ENABLE     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   scheduler_state,
  input  logic [PROGRAM_ADDR_BITS-1:0] current_pc,
  output logic                         mem_read_valid,
  output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
  input  logic                         mem_read_ready,
  input  logic [PROGRAM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                   fetcher_state,
  output logic [PROGRAM_DATA_BITS-1:0] instruction,
  output logic                         fetch_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  fetch_state_t                 state_q, state_d;
  logic                         valid_q, valid_d;
  logic [PROGRAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [PROGRAM_DATA_BITS-1:0] instr_q, instr_d;
  logic                         err_q, err_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         drop_q, drop_d;

  logic                         buf_hit, hit_use, fill_en;
  logic [PROGRAM_DATA_BITS-1:0] buf_data;
  logic                         sched_idle, sched_fetch, sched_decode;
  logic                         drop_now, timeout_hit;

  assign sched_idle   = (scheduler_state == S_IDLE);
  assign sched_fetch  = (scheduler_state == S_FETCH);
  assign sched_decode = (scheduler_state == S_DECODE);
  assign hit_use      = (BUFFER_ENABLE != 0) && buf_hit;
  assign drop_now     = drop_q || sched_idle;
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !mem_read_ready;

  fetch_buffer #(
    .ADDR_W(PROGRAM_ADDR_BITS),
    .DATA_W(PROGRAM_DATA_BITS)
  ) u_fetch_buffer (
    .clk       (clk),
    .reset     (reset),
    .lookup_pc (current_pc),
    .hit       (buf_hit),
    .hit_data  (buf_data),
    .fill_en   (fill_en),
    .fill_pc   (addr_q),
    .fill_data (mem_read_data),
    .invalidate(sched_idle)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= F_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      F_IDLE: begin
        if (sched_fetch) state_d = hit_use ? F_FETCHED : F_FETCHING;
      end
      F_FETCHING: begin
        if (mem_read_ready)   state_d = drop_now ? F_IDLE : F_FETCHED;
        else if (timeout_hit) state_d = F_ERROR;
      end
      F_FETCHED: begin
        if (sched_decode) state_d = F_IDLE;
      end
      F_ERROR: state_d = F_ERROR;
      default: state_d = F_IDLE;
    endcase
  end

  // Memory port: a request is offered while valid is high with a fixed address; it is
  // accepted in the single cycle ready is high, after which valid drops the next cycle.
  // An aborted request stays up until that accept; its data is then discarded.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    fill_en = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (sched_fetch) begin
          if (hit_use) begin
            instr_d = buf_data;
          end else begin
            valid_d = 1'b1;
            addr_d  = current_pc;
            cnt_d   = '0;
            drop_d  = 1'b0;
          end
        end
      end
      F_FETCHING: begin
        if (sched_idle) drop_d = 1'b1;
        if (mem_read_ready) begin
          valid_d = 1'b0;
          drop_d  = 1'b0;
          if (!drop_now) begin
            instr_d = mem_read_data;
            fill_en = (BUFFER_ENABLE != 0);
          end
        end else if (timeout_hit) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      F_FETCHED: ;
      F_ERROR: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
        drop_d  = 1'b0;
      end
    endcase
  end

  assign mem_read_valid   = valid_q;
  assign mem_read_address = addr_q;
  assign fetcher_state    = state_q;
  assign instruction      = instr_q;
  assign fetch_error      = err_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: main instance (64-cycle timeout) and a
// short-timeout instance for the error path.
module tb_instruction_fetcher;

  logic        clk;
  logic        reset;
  logic [2:0]  sched;
  logic [7:0]  pc;
  logic        valid;
  logic [7:0]  addr;
  logic        ready;
  logic [15:0] rdata;
  logic [2:0]  fstate;
  logic [15:0] instr;
  logic        ferr;

  logic        reset_to;
  logic [2:0]  sched_to;
  logic [7:0]  pc_to;
  logic        valid_to;
  logic [7:0]  addr_to;
  logic        ready_to;
  logic [15:0] rdata_to;
  logic [2:0]  fstate_to;
  logic [15:0] instr_to;
  logic        ferr_to;

  int n_checks;
  int n_fail;

  localparam logic [2:0] SI = 3'b000, SF = 3'b001, SD = 3'b010, SE = 3'b101, SU = 3'b110;
  localparam logic [2:0] FI = 3'b000, FG = 3'b001, FD = 3'b010, FE = 3'b011;

  instruction_fetcher dut (
    .clk             (clk),
    .reset           (reset),
    .scheduler_state (sched),
    .current_pc      (pc),
    .mem_read_valid  (valid),
    .mem_read_address(addr),
    .mem_read_ready  (ready),
    .mem_read_data   (rdata),
    .fetcher_state   (fstate),
    .instruction     (instr),
    .fetch_error     (ferr)
  );

  instruction_fetcher #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk             (clk),
    .reset           (reset_to),
    .scheduler_state (sched_to),
    .current_pc      (pc_to),
    .mem_read_valid  (valid_to),
    .mem_read_address(addr_to),
    .mem_read_ready  (ready_to),
    .mem_read_data   (rdata_to),
    .fetcher_state   (fstate_to),
    .instruction     (instr_to),
    .fetch_error     (ferr_to)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset_to = 1'b1;
    sched = SI; pc = '0; ready = 1'b0; rdata = '0;
    sched_to = SI; pc_to = '0; ready_to = 1'b0; rdata_to = '0;
    step(); step();
    reset = 1'b0; reset_to = 1'b0;
    n_checks++;
    if ({fstate, valid, addr, instr, ferr} !== {FI, 1'b0, 8'h00, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_main: got st=%0d v=%b a=%h i=%h e=%b, want all zero", fstate, valid, addr, instr, ferr);
    end
    n_checks++;
    if ({fstate_to, valid_to, addr_to, instr_to, ferr_to} !== {FI, 1'b0, 8'h00, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_timeout_inst: got st=%0d v=%b e=%b, want all zero", fstate_to, valid_to, ferr_to);
    end
  endtask

  task automatic test_basic_fetch();
    sched = SF; pc = 8'h05;
    step();
    n_checks++;
    if ({fstate, valid, addr} !== {FG, 1'b1, 8'h05}) begin
      n_fail++;
      $display("FAIL basic_request: got st=%0d v=%b a=%h, want st=1 v=1 a=05", fstate, valid, addr);
    end
    ready = 1'b1; rdata = 16'h3A7C;
    step();
    ready = 1'b0; rdata = 16'h0000;
    n_checks++;
    if ({fstate, valid, instr} !== {FD, 1'b0, 16'h3A7C}) begin
      n_fail++;
      $display("FAIL basic_fetched: got st=%0d v=%b i=%h, want st=2 v=0 i=3a7c", fstate, valid, instr);
    end
    sched = SD;
    step();
    n_checks++;
    if ({fstate, instr} !== {FI, 16'h3A7C}) begin
      n_fail++;
      $display("FAIL basic_decode_idle: got st=%0d i=%h, want st=0 i=3a7c", fstate, instr);
    end
    sched = SE;
    step();
  endtask

  task automatic test_wait_states();
    sched = SF; pc = 8'h10;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({fstate, valid, addr} !== {FG, 1'b1, 8'h10}) begin
        n_fail++;
        $display("FAIL wait_hold_%0d: got st=%0d v=%b a=%h, want st=1 v=1 a=10", i, fstate, valid, addr);
      end
    end
    ready = 1'b1; rdata = 16'h1234;
    step();
    ready = 1'b0; rdata = 16'h0000;
    n_checks++;
    if ({fstate, valid, instr} !== {FD, 1'b0, 16'h1234}) begin
      n_fail++;
      $display("FAIL wait_accept: got st=%0d v=%b i=%h, want st=2 v=0 i=1234", fstate, valid, instr);
    end
    step();
    n_checks++;
    if ({fstate, valid, instr} !== {FD, 1'b0, 16'h1234}) begin
      n_fail++;
      $display("FAIL wait_hold_fetched: got st=%0d v=%b i=%h, want st=2 v=0 i=1234", fstate, valid, instr);
    end
    sched = SD; step();
    sched = SE; step();
    sched = SU; step();
  endtask

  task automatic test_buffer_hit();
    sched = SF; pc = 8'h10;
    step();
    n_checks++;
    if ({fstate, valid, instr} !== {FD, 1'b0, 16'h1234}) begin
      n_fail++;
      $display("FAIL hit_fetched: got st=%0d v=%b i=%h, want st=2 v=0 i=1234", fstate, valid, instr);
    end
    sched = SD; step();
    n_checks++;
    if (fstate !== FI) begin
      n_fail++;
      $display("FAIL hit_decode_idle: got st=%0d, want 0", fstate);
    end
  endtask

  task automatic test_invalidate();
    sched = SI; step();
    sched = SF; pc = 8'h10;
    step();
    n_checks++;
    if ({fstate, valid, addr} !== {FG, 1'b1, 8'h10}) begin
      n_fail++;
      $display("FAIL inval_miss: got st=%0d v=%b a=%h, want st=1 v=1 a=10", fstate, valid, addr);
    end
    ready = 1'b1; rdata = 16'h5555;
    step();
    ready = 1'b0; rdata = 16'h0000;
    n_checks++;
    if ({fstate, instr} !== {FD, 16'h5555}) begin
      n_fail++;
      $display("FAIL inval_refill: got st=%0d i=%h, want st=2 i=5555", fstate, instr);
    end
    sched = SD; step();
  endtask

  task automatic test_abort();
    sched = SF; pc = 8'h22;
    step();
    sched = SI;
    step();
    n_checks++;
    if ({fstate, valid, addr} !== {FG, 1'b1, 8'h22}) begin
      n_fail++;
      $display("FAIL abort_held: got st=%0d v=%b a=%h, want st=1 v=1 a=22", fstate, valid, addr);
    end
    sched = SD;
    step();
    step();
    n_checks++;
    if ({fstate, valid} !== {FG, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_held_late: got st=%0d v=%b, want st=1 v=1", fstate, valid);
    end
    ready = 1'b1; rdata = 16'hBEEF;
    step();
    ready = 1'b0; rdata = 16'h0000;
    n_checks++;
    if ({fstate, valid, instr} !== {FI, 1'b0, 16'h5555}) begin
      n_fail++;
      $display("FAIL abort_discard: got st=%0d v=%b i=%h, want st=0 v=0 i=5555", fstate, valid, instr);
    end
    sched = SF; pc = 8'h22;
    step();
    n_checks++;
    if ({fstate, valid, addr} !== {FG, 1'b1, 8'h22}) begin
      n_fail++;
      $display("FAIL abort_no_fill: got st=%0d v=%b a=%h, want st=1 v=1 a=22", fstate, valid, addr);
    end
    ready = 1'b1; rdata = 16'h7777;
    step();
    ready = 1'b0; rdata = 16'h0000;
    n_checks++;
    if ({fstate, instr} !== {FD, 16'h7777}) begin
      n_fail++;
      $display("FAIL abort_refetch: got st=%0d i=%h, want st=2 i=7777", fstate, instr);
    end
    sched = SD; step();
  endtask

  task automatic test_timeout();
    sched_to = SF; pc_to = 8'h30;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({fstate_to, valid_to, ferr_to} !== {FG, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL timeout_waiting_%0d: got st=%0d v=%b e=%b, want st=1 v=1 e=0", i, fstate_to, valid_to, ferr_to);
      end
    end
    step();
    n_checks++;
    if ({fstate_to, valid_to, ferr_to} !== {FE, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_error: got st=%0d v=%b e=%b, want st=3 v=0 e=1", fstate_to, valid_to, ferr_to);
    end
    ready_to = 1'b1; rdata_to = 16'hAAAA; sched_to = SI;
    step(); step();
    ready_to = 1'b0;
    n_checks++;
    if ({fstate_to, valid_to, ferr_to, instr_to} !== {FE, 1'b0, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL timeout_sticky: got st=%0d v=%b e=%b i=%h, want st=3 v=0 e=1 i=0000", fstate_to, valid_to, ferr_to, instr_to);
    end
    reset_to = 1'b1;
    step();
    reset_to = 1'b0;
    n_checks++;
    if ({fstate_to, valid_to, ferr_to} !== {FI, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_reset_clears: got st=%0d v=%b e=%b, want all zero", fstate_to, valid_to, ferr_to);
    end
  endtask

  task automatic test_reset_mid_request();
    sched = SF; pc = 8'h44;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; sched = SI;
    n_checks++;
    if ({fstate, valid, addr, instr} !== {FI, 1'b0, 8'h00, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_mid_request: got st=%0d v=%b a=%h i=%h, want all zero", fstate, valid, addr, instr);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_buffer_hit();
    test_invalidate();
    test_abort();
    test_timeout();
    test_reset_mid_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
